// File: rtl/fan_run_scheduler_if.sv
// Request channel between the menu/gesture front end and the fan run scheduler.
// The front end (master) offers a gear/clean request; the scheduler (slave) returns ready.
interface fan_run_scheduler_if;
    logic       req_valid;
    logic [3:0] req_mode;
    logic       req_ready;

    modport master (
        output req_valid,
        output req_mode,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_mode,
        output req_ready
    );
endinterface

// File: rtl/fan_run_scheduler.sv
// Range-hood fan run scheduler: gear selection, timed high-gear burst, self-clean
// countdown, delayed stop, run-time accumulation and clean reminder.
// Optional feature macro: SCHED_BEEP_EN (builds the beep_pulse generator; otherwise 0).
module fan_run_scheduler #(
    parameter int unsigned HIGH_LIMIT_S = 60,
    parameter int unsigned CLEAN_S      = 180,
    parameter int unsigned OFF_DELAY_S  = 10,
    parameter int unsigned CNT_W        = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick_1s,
    input  logic                 power_on,
    fan_run_scheduler_if.slave   req,
    input  logic [15:0]          reminder_limit,
    output logic [1:0]           fan_gear,
    output logic                 cleaning,
    output logic [CNT_W-1:0]     remain_s,
    output logic [15:0]          work_s,
    output logic                 clean_reminder,
    output logic                 beep_pulse
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOW,
        S_MID,
        S_HIGH,
        S_CLEAN,
        S_DELAY_OFF
    } state_t;

    localparam logic [3:0] MODE_OFF   = 4'd0;
    localparam logic [3:0] MODE_LOW   = 4'd1;
    localparam logic [3:0] MODE_MID   = 4'd2;
    localparam logic [3:0] MODE_HIGH  = 4'd3;
    localparam logic [3:0] MODE_CLEAN = 4'd4;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   remain_d;
    logic [15:0]        work_d;
    logic               take_req;
    logic               expire;
    logic               clean_done;

    function automatic logic [1:0] gear_of(input state_t s);
        case (s)
            S_LOW, S_DELAY_OFF: gear_of = 2'd1;
            S_MID:              gear_of = 2'd2;
            S_HIGH, S_CLEAN:    gear_of = 2'd3;
            default:            gear_of = 2'd0;
        endcase
    endfunction

    assign req.req_ready    = power_on & (state_q != S_CLEAN);
    assign clean_reminder   = (work_s >= reminder_limit);

    // Next state and countdown: an effective request overrides the tick; ignored
    // requests (off in IDLE/DELAY_OFF, clean outside IDLE, unknown modes) let the
    // countdown run on; loss of power overrides everything.
    always_comb begin
        state_d    = state_q;
        remain_d   = remain_s;
        take_req   = 1'b0;
        expire     = 1'b0;
        clean_done = 1'b0;

        if (req.req_valid && req.req_ready) begin
            case (req.req_mode)
                MODE_LOW: begin
                    state_d  = S_LOW;
                    remain_d = '0;
                    take_req = 1'b1;
                end
                MODE_MID: begin
                    state_d  = S_MID;
                    remain_d = '0;
                    take_req = 1'b1;
                end
                MODE_HIGH: begin
                    state_d  = S_HIGH;
                    remain_d = CNT_W'(HIGH_LIMIT_S);
                    take_req = 1'b1;
                end
                MODE_OFF: begin
                    if (state_q inside {S_LOW, S_MID, S_HIGH}) begin
                        state_d  = S_DELAY_OFF;
                        remain_d = CNT_W'(OFF_DELAY_S);
                        take_req = 1'b1;
                    end
                end
                MODE_CLEAN: begin
                    if (state_q == S_IDLE) begin
                        state_d  = S_CLEAN;
                        remain_d = CNT_W'(CLEAN_S);
                        take_req = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        if (!take_req && tick_1s && (state_q inside {S_HIGH, S_CLEAN, S_DELAY_OFF})) begin
            if (remain_s == CNT_W'(1)) begin
                remain_d = '0;
                expire   = 1'b1;
                state_d  = (state_q == S_HIGH) ? S_MID : S_IDLE;
            end else begin
                remain_d = remain_s - CNT_W'(1);
            end
        end

        if (!power_on) begin
            state_d  = S_IDLE;
            remain_d = '0;
            expire   = 1'b0;
        end

        clean_done = expire && (state_q == S_CLEAN);
    end

    // Run-time accumulator: counts powered-fan seconds outside self-clean, saturating.
    always_comb begin
        work_d = work_s;
        if (tick_1s && (fan_gear != 2'd0) && (state_q != S_CLEAN) && (work_s != '1)) begin
            work_d = work_s + 16'd1;
        end
        if (clean_done) begin
            work_d = '0;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            fan_gear <= '0;
            cleaning <= 1'b0;
            remain_s <= '0;
            work_s   <= '0;
        end else begin
            state_q  <= state_d;
            fan_gear <= gear_of(state_d);
            cleaning <= (state_d == S_CLEAN);
            remain_s <= remain_d;
            work_s   <= work_d;
        end
    end

`ifdef SCHED_BEEP_EN
    logic reminder_q;

    // One-clk beep on high-gear timeout, clean completion and a rising clean reminder.
    always_ff @(posedge clk) begin
        if (reset) begin
            beep_pulse <= 1'b0;
            reminder_q <= 1'b0;
        end else begin
            beep_pulse <= (expire && (state_q inside {S_HIGH, S_CLEAN}))
                          || (clean_reminder && !reminder_q);
            reminder_q <= clean_reminder;
        end
    end
`else
    assign beep_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_fan_run_scheduler.sv
// Self-checking bench for fan_run_scheduler: directed scenarios followed by random
// stimulus, every cycle compared against a behavioural model of the hood.
module tb_fan_run_scheduler;

    localparam int unsigned CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             tick_1s;
    logic             power_on;
    logic [15:0]      reminder_limit;
    logic [1:0]       fan_gear;
    logic             cleaning;
    logic [CNT_W-1:0] remain_s;
    logic [15:0]      work_s;
    logic             clean_reminder;
    logic             beep_pulse;

    fan_run_scheduler_if req_if ();

    fan_run_scheduler #(
        .HIGH_LIMIT_S (60),
        .CLEAN_S      (180),
        .OFF_DELAY_S  (10),
        .CNT_W        (CNT_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .tick_1s        (tick_1s),
        .power_on       (power_on),
        .req            (req_if),
        .reminder_limit (reminder_limit),
        .fan_gear       (fan_gear),
        .cleaning       (cleaning),
        .remain_s       (remain_s),
        .work_s         (work_s),
        .clean_reminder (clean_reminder),
        .beep_pulse     (beep_pulse)
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Behavioural hood model: what the hood is doing, seconds left, seconds run.
    typedef enum int {H_OFF, H_LOW, H_MID, H_HIGH, H_CLEAN, H_RUN_ON} hood_t;
    hood_t m_hood = H_OFF;
    int    m_left = 0;
    int    m_work = 0;
    bit    m_rem_was = 1'b0;
    bit    m_beep = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int speed(input hood_t h);
        case (h)
            H_LOW, H_RUN_ON: return 1;
            H_MID:           return 2;
            H_HIGH, H_CLEAN: return 3;
            default:         return 0;
        endcase
    endfunction

    function automatic void model_step();
        bit    rem_now;
        bit    took;
        hood_t was;
        rem_now = (m_work >= int'(reminder_limit));
        m_beep  = 1'b0;
        if (reset) begin
            m_hood = H_OFF; m_left = 0; m_work = 0; m_rem_was = 1'b0;
            return;
        end
        was  = m_hood;
        took = 1'b0;
        if (tick_1s && speed(was) != 0 && was != H_CLEAN && m_work < 65535) m_work++;
        if (!power_on) begin
            m_hood = H_OFF;
            m_left = 0;
        end else begin
            if (req_if.req_valid && was != H_CLEAN) begin
                case (int'(req_if.req_mode))
                    1: begin m_hood = H_LOW;  m_left = 0;  took = 1'b1; end
                    2: begin m_hood = H_MID;  m_left = 0;  took = 1'b1; end
                    3: begin m_hood = H_HIGH; m_left = 60; took = 1'b1; end
                    0: if (was == H_LOW || was == H_MID || was == H_HIGH) begin
                           m_hood = H_RUN_ON; m_left = 10; took = 1'b1;
                       end
                    4: if (was == H_OFF) begin
                           m_hood = H_CLEAN; m_left = 180; took = 1'b1;
                       end
                    default: ;
                endcase
            end
            if (!took && tick_1s && m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    if (was == H_HIGH) begin
                        m_hood = H_MID;
`ifdef SCHED_BEEP_EN
                        m_beep = 1'b1;
`endif
                    end else begin
                        if (was == H_CLEAN) begin
                            m_work = 0;
`ifdef SCHED_BEEP_EN
                            m_beep = 1'b1;
`endif
                        end
                        m_hood = H_OFF;
                    end
                end
            end
        end
`ifdef SCHED_BEEP_EN
        if (rem_now && !m_rem_was) m_beep = 1'b1;
`endif
        m_rem_was = rem_now;
    endfunction

    task automatic check_outputs();
        check_eq("fan_gear", 32'(fan_gear), 32'(speed(m_hood)));
        check_eq("cleaning", 32'(cleaning), 32'(m_hood == H_CLEAN));
        check_eq("remain_s", 32'(remain_s), 32'(m_left));
        check_eq("work_s", 32'(work_s), 32'(m_work));
        check_eq("clean_reminder", 32'(clean_reminder), 32'(m_work >= int'(reminder_limit)));
        check_eq("beep_pulse", 32'(beep_pulse), 32'(m_beep));
    endtask

    // Inputs are set at the falling edge before calling; ready is checked before the edge.
    task automatic cycle();
        #1;
        if (!reset) check_eq("req_ready", 32'(req_if.req_ready), 32'(power_on && m_hood != H_CLEAN));
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    task automatic request(input logic [3:0] mode, input bit with_tick);
        req_if.req_valid = 1'b1;
        req_if.req_mode  = mode;
        tick_1s          = with_tick;
        cycle();
        req_if.req_valid = 1'b0;
        tick_1s          = 1'b0;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            tick_1s = 1'b1; cycle();
            tick_1s = 1'b0; cycle();
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1; cycle(); reset = 1'b0;
    endtask

    initial begin
        reset            = 1'b1;
        power_on         = 1'b1;
        tick_1s          = 1'b0;
        req_if.req_valid = 1'b0;
        req_if.req_mode  = '0;
        reminder_limit   = 16'hFFFF;
        @(negedge clk);
        pulse_reset();
        check_eq("rst_gear", 32'(fan_gear), 0);
        check_eq("rst_remain", 32'(remain_s), 0);
        check_eq("rst_work", 32'(work_s), 0);
        check_eq("rst_beep", 32'(beep_pulse), 0);

        // Low gear and run-time counting
        request(4'd1, 1'b0);
        check_eq("low_gear", 32'(fan_gear), 1);
        tick_n(5);
        check_eq("low_work5", 32'(work_s), 5);

        // High burst and timeout to mid
        request(4'd3, 1'b0);
        check_eq("high_gear", 32'(fan_gear), 3);
        check_eq("high_remain", 32'(remain_s), 60);
        tick_n(59);
        check_eq("high_remain1", 32'(remain_s), 1);
        tick_1s = 1'b1; cycle(); tick_1s = 1'b0;
        check_eq("high_to_mid", 32'(fan_gear), 2);
        check_eq("high_to_mid_remain", 32'(remain_s), 0);
`ifdef SCHED_BEEP_EN
        check_eq("high_timeout_beep", 32'(beep_pulse), 1);
`else
        check_eq("high_timeout_beep", 32'(beep_pulse), 0);
`endif
        cycle();
        check_eq("beep_one_clk", 32'(beep_pulse), 0);

        // Bring work_s to 300 in IDLE, then self-clean
        tick_n(225);
        request(4'd0, 1'b0);
        check_eq("off_gear", 32'(fan_gear), 1);
        check_eq("off_remain", 32'(remain_s), 10);
        tick_n(10);
        check_eq("idle_gear", 32'(fan_gear), 0);
        check_eq("work300", 32'(work_s), 300);
        reminder_limit = 16'd200;
        cycle();
        request(4'd4, 1'b0);
        check_eq("clean_flag", 32'(cleaning), 1);
        check_eq("clean_gear", 32'(fan_gear), 3);
        #1 check_eq("clean_ready", 32'(req_if.req_ready), 0);
        request(4'd1, 1'b0);
        check_eq("clean_ignores_low", 32'(cleaning), 1);
        tick_n(180);
        check_eq("clean_done_gear", 32'(fan_gear), 0);
        check_eq("clean_done_work", 32'(work_s), 0);
        check_eq("clean_done_rem", 32'(clean_reminder), 0);

        // Delayed stop interrupted by high, off in IDLE, unknown mode
        request(4'd2, 1'b0);
        request(4'd0, 1'b0);
        tick_n(6);
        check_eq("runon_remain4", 32'(remain_s), 4);
        request(4'd3, 1'b0);
        check_eq("runon_to_high", 32'(fan_gear), 3);
        check_eq("runon_high_remain", 32'(remain_s), 60);
        request(4'd0, 1'b0);
        tick_n(10);
        request(4'd0, 1'b0);
        check_eq("off_in_idle_gear", 32'(fan_gear), 0);
        check_eq("off_in_idle_remain", 32'(remain_s), 0);
        request(4'd9, 1'b0);
        check_eq("bad_mode_gear", 32'(fan_gear), 0);

        // Reminder threshold and request coincident with tick
        pulse_reset();
        reminder_limit = 16'd3;
        request(4'd1, 1'b0);
        tick_n(2);
        check_eq("rem_before", 32'(clean_reminder), 0);
        tick_1s = 1'b1; cycle(); tick_1s = 1'b0;
        check_eq("rem_third_tick", 32'(clean_reminder), 1);
        cycle();
        request(4'd3, 1'b1);
        check_eq("req_tick_remain", 32'(remain_s), 60);
        check_eq("req_tick_work", 32'(work_s), 4);

        // Power loss during clean, reset during high
        power_on = 1'b0; cycle(); power_on = 1'b1;
        request(4'd4, 1'b0);
        tick_n(90);
        check_eq("clean_remain90", 32'(remain_s), 90);
        power_on = 1'b0; cycle();
        check_eq("pwr_gear", 32'(fan_gear), 0);
        check_eq("pwr_clean", 32'(cleaning), 0);
        check_eq("pwr_remain", 32'(remain_s), 0);
        check_eq("pwr_work", 32'(work_s), 4);
        check_eq("pwr_beep", 32'(beep_pulse), 0);
        #1 check_eq("pwr_ready", 32'(req_if.req_ready), 0);
        power_on = 1'b1;
        request(4'd3, 1'b0);
        tick_n(5);
        pulse_reset();
        check_eq("midhigh_rst_gear", 32'(fan_gear), 0);
        check_eq("midhigh_rst_remain", 32'(remain_s), 0);
        check_eq("midhigh_rst_work", 32'(work_s), 0);

        // Random traffic
        reminder_limit = 16'd500;
        for (int i = 0; i < 20000; i++) begin
            reset            = ($urandom_range(0, 2999) == 0);
            power_on         = ($urandom_range(0, 499) != 0);
            tick_1s          = ($urandom_range(0, 3) != 0);
            req_if.req_valid = ($urandom_range(0, 19) == 0);
            req_if.req_mode  = 4'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) req_if.req_mode = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 799) == 0) reminder_limit = 16'($urandom_range(0, 2000));
            cycle();
        end
        reset            = 1'b0;
        req_if.req_valid = 1'b0;
        tick_1s          = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
